muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the HI/LO registers.
//  - Sits beside the EX-stage ALU and accepts an op when the R-type Funct selects it.
//  - Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle.
//  - Raises stall so hazard control freezes IF/ID/EX while a result or HI/LO access is pending.

---
 rtl/muldiv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit that sits beside the EX-stage ALU and owns
// the HI/LO register pair. MULT/MULTU use shift-add and DIV/DIVU use restoring
// subtraction. Each op runs one step per cycle for WIDTH cycles, then takes one
// fix-up cycle that applies the sign and writes HI/LO. MTHI/MTLO write HI/LO
// directly when the unit is idle. While an op is in flight, any HI/LO-related
// instruction waiting in EX is held off through 'stall'.
//
// Ports
//   clk    in   1      clock; all state changes on the rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      EX holds a valid R-type instruction this cycle
//   Funct  in   6      24 MULT, 25 MULTU, 26 DIV, 27 DIVU,
//                      16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO
//   A      in   WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data)
//   B      in   WIDTH  rt operand (multiplier / divisor)
//   HI     out  WIDTH  HI register
//   LO     out  WIDTH  LO register
//   busy   out  1      an operation is in progress
//   stall  out  1      busy and EX holds a mul/div or HI/LO access
//   done   out  1      one-cycle pulse after HI/LO take a mul/div result
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam logic [5:0] FN_MTHI = 6'd17;
    localparam logic [5:0] FN_MTLO = 6'd19;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_q;     // upper product half / partial remainder
    logic [WIDTH-1:0] low_q;     // multiplier then lower product / dividend then quotient
    logic [WIDTH-1:0] opB_q;     // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             isDiv_q;
    logic             negRes_q;  // signed op with operands of opposite sign
    logic             negRem_q;  // signed divide with a negative dividend
    logic             done_q;

    // Funct 24..27 share the pattern 0110xx, and 16..19 share 0100xx.
    // Within mul/div, bit 0 marks the unsigned form and bit 1 marks divide.
    logic isMulDiv;
    logic isHiLo;
    logic isSigned;
    logic isDivOp;

    assign isMulDiv = (Funct[5:2] == 4'b0110);
    assign isHiLo   = (Funct[5:2] == 4'b0100);
    assign isSigned = ~Funct[0];
    assign isDivOp  = Funct[1];

    logic             negA;
    logic             negB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign negA = isSigned & A[WIDTH-1];
    assign negB = isSigned & B[WIDTH-1];
    assign absA = negA ? -A : A;
    assign absB = negB ? -B : B;

    // One shift-add step. The carry out of the add shifts into the upper half.
    logic [WIDTH:0]   mulAddend;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulAccStep;
    logic [WIDTH-1:0] mulLowStep;

    assign mulAddend  = low_q[0] ? {1'b0, opB_q} : '0;
    assign mulSum     = {1'b0, acc_q} + mulAddend;
    assign mulAccStep = mulSum[WIDTH:1];
    assign mulLowStep = {mulSum[0], low_q[WIDTH-1:1]};

    // One restoring-divide step. The next dividend bit shifts into the
    // remainder, and the quotient bit shifts in at the bottom of low_q.
    // A clear borrow bit means the trial subtraction fits.
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   divDiff;
    logic             qBit;
    logic [WIDTH-1:0] divAccStep;
    logic [WIDTH-1:0] divLowStep;

    assign remShift   = {acc_q, low_q[WIDTH-1]};
    assign divDiff    = remShift - {1'b0, opB_q};
    assign qBit       = ~divDiff[WIDTH];
    assign divAccStep = qBit ? divDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign divLowStep = {low_q[WIDTH-2:0], qBit};

    // Fix-up values. For a signed divide by zero, the remainder path rebuilds
    // the raw dividend on its own; the quotient is forced to all ones below.
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    assign product = {acc_q, low_q};
    assign prodFix = negRes_q ? -product : product;
    assign quotFix = negRes_q ? -low_q : low_q;
    assign remFix  = negRem_q ? -acc_q : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            opB_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && isMulDiv) begin
                        acc_q    <= '0;
                        low_q    <= absA;
                        opB_q    <= absB;
                        isDiv_q  <= isDivOp;
                        negRes_q <= negA ^ negB;
                        negRem_q <= negA;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end else if (start && (Funct == FN_MTHI)) begin
                        hi_q <= A;
                    end else if (start && (Funct == FN_MTLO)) begin
                        lo_q <= A;
                    end
                end
                RUN: begin
                    if (isDiv_q) begin
                        acc_q <= divAccStep;
                        low_q <= divLowStep;
                    end else begin
                        acc_q <= mulAccStep;
                        low_q <= mulLowStep;
                    end
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (isDiv_q) begin
                        hi_q <= remFix;
                        lo_q <= (opB_q == '0) ? '1 : quotFix;
                    end else begin
                        hi_q <= prodFix[2*WIDTH-1:WIDTH];
                        lo_q <= prodFix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign stall = busy & start & (isMulDiv | isHiLo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Testbench for muldiv_sequencer with a scoreboard. The stimulus side issues
// instructions and pushes the expected HI/LO and completion cycle of every
// mul/div. A separate monitor checks each done pulse against the oldest entry.
// The reference uses plain 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MTHI  = 6'd17;
    localparam logic [5:0] MFLO  = 6'd18;
    localparam logic [5:0] MTLO  = 6'd19;
    localparam logic [5:0] MULT  = 6'd24;
    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] DIV   = 6'd26;
    localparam logic [5:0] DIVU  = 6'd27;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   Funct;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         busy;
    logic         stall;
    logic         done;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Funct (Funct),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .stall (stall),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int unsigned  cycle;
    } exp_t;

    exp_t         expQ[$];
    int           checks = 0;
    int           passes = 0;
    int unsigned  cyc    = 0;
    logic [W-1:0] hiModel = '0;
    logic [W-1:0] loModel = '0;

    // Count rising edges so completion latency can be checked in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference behaviour in plain integer arithmetic
    function automatic void refModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (f)
            MULT: begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            MULTU: begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            DIV: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    sp = sa / sb;
                    lo = sp[31:0];
                    sp = sa % sb;
                    hi = sp[31:0];
                end
            end
            DIVU: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    up = ua / ub;
                    lo = up[31:0];
                    up = ua % ub;
                    hi = up[31:0];
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("result_hi", HI, e.hi);
                checkOutput("result_lo", LO, e.lo);
                checkOutput("done_cycle", cyc, e.cycle);
                hiModel = e.hi;
                loModel = e.lo;
            end
        end
    end

    // Hold an instruction in EX until it is accepted, the way the pipeline
    // would. While held, stall must be high and HI/LO must not move.
    task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int           waited;
        logic [W-1:0] hiHeld;
        logic [W-1:0] loHeld;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        exp_t         e;
        waited = 0;
        @(negedge clk);
        start = 1'b1;
        Funct = f;
        A     = a;
        B     = b;
        #1;
        hiHeld = HI;
        loHeld = LO;
        while (busy && waited < 200) begin
            checkOutput("stall_while_busy", stall, 1);
            checkOutput("hi_stable_busy", HI, hiHeld);
            checkOutput("lo_stable_busy", LO, loHeld);
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            $display("[TB] FAIL busy_timeout: got busy=1 after %0d cycles, expected idle", waited);
        end
        checkOutput("stall_idle", stall, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        case (f)
            MULT, MULTU, DIV, DIVU: begin
                refModel(f, a, b, eh, el);
                e.hi    = eh;
                e.lo    = el;
                e.cycle = cyc + W + 1;
                expQ.push_back(e);
                checkOutput("busy_after_start", busy, 1);
            end
            MTHI: begin
                hiModel = a;
                checkOutput("mthi_write", HI, a);
                checkOutput("busy_after_mt", busy, 0);
            end
            MTLO: begin
                loModel = a;
                checkOutput("mtlo_write", LO, a);
                checkOutput("busy_after_mt", busy, 0);
            end
            MFHI: checkOutput("mfhi_read", HI, hiModel);
            MFLO: checkOutput("mflo_read", LO, loModel);
            default: ;
        endcase
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("[TB] FAIL idle_timeout: got busy=1, expected idle within 200 cycles");
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] f;
        int         r;
        rst   = 1'b1;
        start = 1'b0;
        Funct = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", HI, 0);
        checkOutput("reset_lo", LO, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_stall", stall, 0);

        // Directed corner cases
        applyStimulus(MULTU, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(MULT, -32'sd3, 32'sd7);
        applyStimulus(DIV, -32'sd7, 32'sd2);
        applyStimulus(DIVU, 32'd100, 32'd0);
        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(DIV, -32'sd5, 32'd0);
        waitIdle();

        // MFLO arriving a few cycles into a multiply waits for completion
        applyStimulus(MULT, 32'd12345, -32'sd678);
        repeat (4) @(negedge clk);
        applyStimulus(MFLO, '0, '0);
        applyStimulus(MFHI, '0, '0);

        // MTHI in idle, then MTLO held behind a busy divide
        applyStimulus(MTHI, 32'h1234, '0);
        applyStimulus(DIVU, 32'd1000, 32'd7);
        applyStimulus(MTLO, 32'hCAFE_F00D, '0);
        applyStimulus(MFLO, '0, '0);

        // Reset partway through a run abandons the result
        applyStimulus(MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clk);
        expQ.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        hiModel = '0;
        loModel = '0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_hi", HI, 0);
        checkOutput("midreset_lo", LO, 0);
        repeat (40) begin
            @(negedge clk);
            checkOutput("midreset_no_done", done, 0);
        end
        applyStimulus(MULTU, 32'd6, 32'd7);
        waitIdle();
        checkOutput("mul6x7_lo", LO, 42);

        // Randomized back-to-back traffic
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 11);
            if (r < 8) begin
                f = MULT + 6'(r % 4);
                applyStimulus(f, pickOperand(), pickOperand());
            end else begin
                case (r)
                    8:       f = MFHI;
                    9:       f = MTHI;
                    10:      f = MFLO;
                    default: f = MTLO;
                endcase
                applyStimulus(f, W'($urandom), '0);
            end
        end
        waitIdle();
        checkOutput("queue_drained", expQ.size(), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
